hazard_unit: RTL and testbench

- Parametrised hazard and forwarding controller for the 5-stage pipelined MIPS CPU.
- Generalises the fixed EXE/MEM forwarding logic to FWD_STAGES producer stages.
- Adds ID-stage branch operand hazards, a multi-cycle EXE operation counter (MUL/DIV), a branch-flush path and a saturating stall performance counter.
- Sits beside the decode controller and drives all stage enable/reset signals.

---
 rtl/hazard_unit_if.sv | 48 ++++
 rtl/hazard_unit.sv | 186 ++++++++++++++++++
 tb/tb_hazard_unit.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_unit_if.sv
// hazard_unit_if: groups the hazard controller's pipeline-facing signals.
//   Pipeline -> hazard unit: debug_en/debug_step, ID operand info
//     (id_rs_addr, id_rt_addr, id_rs_used, id_rt_used, id_is_branch,
//     id_mc_start), branch_taken, and per-producer-stage info
//     (stg_wen, stg_waddr, stg_is_load; stage k at bit/field k).
//   Hazard unit -> pipeline: fwd_a/fwd_b operand selects, stage enables
//     (*_en), stage bubble resets (*_rst), data_stall, mc_busy, stall_cnt.
//   master = pipeline side, slave = hazard unit side.
interface hazard_unit_if #(
   parameter int ADDR_W     = 5,
   parameter int FWD_STAGES = 3,
   parameter int FS_W       = 2,
   parameter int CNT_W      = 16
);
   logic                           debug_en;
   logic                           debug_step;
   logic [ADDR_W-1:0]              id_rs_addr;
   logic [ADDR_W-1:0]              id_rt_addr;
   logic                           id_rs_used;
   logic                           id_rt_used;
   logic                           id_is_branch;
   logic                           id_mc_start;
   logic                           branch_taken;
   logic [FWD_STAGES-1:0]          stg_wen;
   logic [FWD_STAGES*ADDR_W-1:0]   stg_waddr;
   logic [FWD_STAGES-1:0]          stg_is_load;
   logic [FS_W-1:0]                fwd_a;
   logic [FS_W-1:0]                fwd_b;
   logic                           if_en, id_en, exe_en, mem_en, wb_en;
   logic                           if_rst, id_rst, exe_rst, mem_rst, wb_rst;
   logic                           data_stall;
   logic                           mc_busy;
   logic [CNT_W-1:0]               stall_cnt;

   modport master (
      output debug_en, debug_step, id_rs_addr, id_rt_addr, id_rs_used, id_rt_used,
             id_is_branch, id_mc_start, branch_taken, stg_wen, stg_waddr, stg_is_load,
      input  fwd_a, fwd_b, if_en, id_en, exe_en, mem_en, wb_en,
             if_rst, id_rst, exe_rst, mem_rst, wb_rst, data_stall, mc_busy, stall_cnt
   );

   modport slave (
      input  debug_en, debug_step, id_rs_addr, id_rt_addr, id_rs_used, id_rt_used,
             id_is_branch, id_mc_start, branch_taken, stg_wen, stg_waddr, stg_is_load,
      output fwd_a, fwd_b, if_en, id_en, exe_en, mem_en, wb_en,
             if_rst, id_rst, exe_rst, mem_rst, wb_rst, data_stall, mc_busy, stall_cnt
   );
endinterface

// File: rtl/hazard_unit.sv
// hazard_unit: forwarding and hazard controller for the 5-stage MIPS pipeline.
//   clk, rst : clock and synchronous active-high reset.
//   bus      : hazard_unit_if slave port. Takes ID operand info and producer
//              stage info (0=EXE, 1=MEM, 2=WB), returns forwarding selects,
//              stage enables/bubble resets, data_stall, mc_busy and a
//              saturating stalled-cycle counter.
module hazard_unit #(
   parameter int ADDR_W     = 5,
   parameter int FWD_STAGES = 3,
   parameter int FS_W       = 2,
   parameter int MC_LAT     = 4,
   parameter int CNT_W      = 16
) (
   input logic          clk,
   input logic          rst,
   hazard_unit_if.slave bus
);
   // MC_LAT-1 always fits in clog2(MC_LAT) bits for MC_LAT >= 2.
   localparam int MC_W = $clog2(MC_LAT);
   // Index of the MEM stage load flag, clamped so a 1-stage build still elaborates.
   localparam int LD1  = (FWD_STAGES > 1) ? 1 : 0;

   // Youngest matching producer wins: scan from oldest to youngest so the
   // lowest index overwrites.
   function automatic logic [FS_W-1:0] fwd_sel(
      input logic [ADDR_W-1:0]            addr,
      input logic                         used,
      input logic [FWD_STAGES-1:0]        wen,
      input logic [FWD_STAGES*ADDR_W-1:0] waddr
   );
      logic [FS_W-1:0] sel;
      sel = '0;
      for (int k = FWD_STAGES - 1; k >= 0; k--) begin
         if (used && (addr != '0) && wen[k] && (waddr[k*ADDR_W +: ADDR_W] == addr)) begin
            sel = FS_W'(k + 1);
         end else begin
            sel = sel;
         end
      end
      return sel;
   endfunction

   // A load still in EXE can never be forwarded in time; a branch compares in
   // ID so it also cannot use an EXE result or a MEM-stage load.
   function automatic logic opnd_stall(
      input logic [FS_W-1:0]       sel,
      input logic                  is_branch,
      input logic [FWD_STAGES-1:0] is_load
   );
      logic s;
      if (sel == FS_W'(1)) begin
         s = is_load[0] | is_branch;
      end else if (sel == FS_W'(2)) begin
         s = is_branch & (FWD_STAGES > 1) & is_load[LD1];
      end else begin
         s = 1'b0;
      end
      return s;
   endfunction

   logic [FS_W-1:0]  fwd_a_s, fwd_b_s;
   logic             data_stall_s;
   logic             step_prev_r, step_edge_s, dbg_susp_s;
   logic [MC_W-1:0]  mc_cnt_r;
   logic             mc_busy_s, mc_load_s;
   logic [CNT_W-1:0] stall_cnt_r;
   logic             stall_inc_s;
   logic             if_en_s, id_en_s, exe_en_s, mem_en_s, wb_en_s;
   logic             if_rst_s, id_rst_s, exe_rst_s, mem_rst_s, wb_rst_s;

   // Forwarding selects and load-use / branch operand stall detection.
   always_comb begin
      fwd_a_s      = '0;
      fwd_b_s      = '0;
      data_stall_s = 1'b0;
      if (rst) begin
         fwd_a_s      = '0;
         fwd_b_s      = '0;
         data_stall_s = 1'b0;
      end else begin
         fwd_a_s      = fwd_sel(bus.id_rs_addr, bus.id_rs_used, bus.stg_wen, bus.stg_waddr);
         fwd_b_s      = fwd_sel(bus.id_rt_addr, bus.id_rt_used, bus.stg_wen, bus.stg_waddr);
         data_stall_s = opnd_stall(fwd_a_s, bus.id_is_branch, bus.stg_is_load) |
                        opnd_stall(fwd_b_s, bus.id_is_branch, bus.stg_is_load);
      end
   end

   assign step_edge_s = bus.debug_step & ~step_prev_r;
   assign dbg_susp_s  = ~rst & bus.debug_en & ~step_edge_s;
   assign mc_busy_s   = (mc_cnt_r != '0);
   assign mc_load_s   = bus.id_mc_start & id_en_s & ~data_stall_s & ~mc_busy_s;
   assign stall_inc_s = ~rst & ~dbg_susp_s & (mc_busy_s | data_stall_s);

   // Stage enable/bubble control in priority order: reset, debug hold,
   // multi-cycle occupancy, data stall, branch flush. A stall suppresses the
   // flush so the branch re-evaluates once its operands are ready.
   always_comb begin
      if_en_s   = 1'b1;
      id_en_s   = 1'b1;
      exe_en_s  = 1'b1;
      mem_en_s  = 1'b1;
      wb_en_s   = 1'b1;
      if_rst_s  = 1'b0;
      id_rst_s  = 1'b0;
      exe_rst_s = 1'b0;
      mem_rst_s = 1'b0;
      wb_rst_s  = 1'b0;
      if (rst) begin
         if_rst_s  = 1'b1;
         id_rst_s  = 1'b1;
         exe_rst_s = 1'b1;
         mem_rst_s = 1'b1;
         wb_rst_s  = 1'b1;
      end else if (dbg_susp_s) begin
         if_en_s  = 1'b0;
         id_en_s  = 1'b0;
         exe_en_s = 1'b0;
         mem_en_s = 1'b0;
         wb_en_s  = 1'b0;
      end else if (mc_busy_s) begin
         if_en_s   = 1'b0;
         id_en_s   = 1'b0;
         exe_en_s  = 1'b0;
         mem_rst_s = 1'b1;
      end else if (data_stall_s) begin
         if_en_s   = 1'b0;
         id_en_s   = 1'b0;
         exe_rst_s = 1'b1;
      end else if (bus.branch_taken) begin
         id_rst_s = 1'b1;
      end else begin
         id_rst_s = 1'b0;
      end
   end

   // Debug step edge detector history.
   always_ff @(posedge clk) begin
      if (rst) begin
         step_prev_r <= 1'b0;
      end else begin
         step_prev_r <= bus.debug_step;
      end
   end

   // Multi-cycle EXE occupancy counter; frozen while debug holds the pipe.
   always_ff @(posedge clk) begin
      if (rst) begin
         mc_cnt_r <= '0;
      end else if (dbg_susp_s) begin
         mc_cnt_r <= mc_cnt_r;
      end else if (mc_busy_s) begin
         mc_cnt_r <= mc_cnt_r - MC_W'(1);
      end else if (mc_load_s) begin
         mc_cnt_r <= MC_W'(MC_LAT - 1);
      end else begin
         mc_cnt_r <= mc_cnt_r;
      end
   end

   // Saturating count of cycles lost to multi-cycle occupancy or data stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_r <= '0;
      end else if (stall_inc_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
         stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   assign bus.fwd_a      = fwd_a_s;
   assign bus.fwd_b      = fwd_b_s;
   assign bus.data_stall = data_stall_s;
   assign bus.mc_busy    = mc_busy_s;
   assign bus.stall_cnt  = stall_cnt_r;
   assign bus.if_en      = if_en_s;
   assign bus.id_en      = id_en_s;
   assign bus.exe_en     = exe_en_s;
   assign bus.mem_en     = mem_en_s;
   assign bus.wb_en      = wb_en_s;
   assign bus.if_rst     = if_rst_s;
   assign bus.id_rst     = id_rst_s;
   assign bus.exe_rst    = exe_rst_s;
   assign bus.mem_rst    = mem_rst_s;
   assign bus.wb_rst     = wb_rst_s;
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: self-checking bench for hazard_unit. Two instances share the
// same stimulus: one with a 16-bit stall counter, one with a 4-bit counter to
// exercise saturation. Expected values come from a cycle-level model.
module tb_hazard_unit;
   localparam int AW = 5;
   localparam int NS = 3;
   localparam int FW = 2;
   localparam int ML = 4;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   hazard_unit_if #(.ADDR_W(AW), .FWD_STAGES(NS), .FS_W(FW), .CNT_W(16)) hif ();
   hazard_unit_if #(.ADDR_W(AW), .FWD_STAGES(NS), .FS_W(FW), .CNT_W(4))  hif4 ();

   hazard_unit #(.ADDR_W(AW), .FWD_STAGES(NS), .FS_W(FW), .MC_LAT(ML), .CNT_W(16))
      dut (.clk(clk), .rst(rst), .bus(hif));
   hazard_unit #(.ADDR_W(AW), .FWD_STAGES(NS), .FS_W(FW), .MC_LAT(ML), .CNT_W(4))
      dut4 (.clk(clk), .rst(rst), .bus(hif4));

   assign hif4.debug_en     = hif.debug_en;
   assign hif4.debug_step   = hif.debug_step;
   assign hif4.id_rs_addr   = hif.id_rs_addr;
   assign hif4.id_rt_addr   = hif.id_rt_addr;
   assign hif4.id_rs_used   = hif.id_rs_used;
   assign hif4.id_rt_used   = hif.id_rt_used;
   assign hif4.id_is_branch = hif.id_is_branch;
   assign hif4.id_mc_start  = hif.id_mc_start;
   assign hif4.branch_taken = hif.branch_taken;
   assign hif4.stg_wen      = hif.stg_wen;
   assign hif4.stg_waddr    = hif.stg_waddr;
   assign hif4.stg_is_load  = hif.stg_is_load;

   always #5 clk = ~clk;

   // Reference model state: remaining busy cycles, step history, stall counts.
   int  m_mc = 0, m_cnt16 = 0, m_cnt4 = 0;
   bit  m_prev = 1'b0;
   // Expected outputs; en/rs ordered {if, id, exe, mem, wb}.
   logic [1:0] e_fwd_a, e_fwd_b;
   logic       e_stall, e_busy, e_susp;
   logic [4:0] e_en, e_rs;

   function automatic logic [4:0] act_en();
      return {hif.if_en, hif.id_en, hif.exe_en, hif.mem_en, hif.wb_en};
   endfunction
   function automatic logic [4:0] act_rs();
      return {hif.if_rst, hif.id_rst, hif.exe_rst, hif.mem_rst, hif.wb_rst};
   endfunction

   function automatic int ref_fwd(logic [AW-1:0] addr, logic used);
      for (int k = 0; k < NS; k++) begin
         if (used && addr != 0 && hif.stg_wen[k] && hif.stg_waddr[k*AW +: AW] == addr) return k + 1;
      end
      return 0;
   endfunction

   function automatic bit ref_stall(int f);
      if (f == 1) return hif.stg_is_load[0] || hif.id_is_branch;
      if (f == 2) return hif.id_is_branch && hif.stg_is_load[1];
      return 1'b0;
   endfunction

   task automatic model_eval();
      int fa, fb;
      fa = ref_fwd(hif.id_rs_addr, hif.id_rs_used);
      fb = ref_fwd(hif.id_rt_addr, hif.id_rt_used);
      e_fwd_a = rst ? 2'd0 : 2'(fa);
      e_fwd_b = rst ? 2'd0 : 2'(fb);
      e_stall = !rst && (ref_stall(fa) || ref_stall(fb));
      e_busy  = (m_mc != 0);
      e_susp  = !rst && hif.debug_en && !(hif.debug_step && !m_prev);
      e_en = 5'b11111;
      e_rs = 5'b00000;
      if (rst)                   e_rs = 5'b11111;
      else if (e_susp)           e_en = 5'b00000;
      else if (e_busy)           begin e_en = 5'b00011; e_rs = 5'b00010; end
      else if (e_stall)          begin e_en = 5'b00111; e_rs = 5'b00100; end
      else if (hif.branch_taken) e_rs = 5'b01000;
   endtask

   task automatic settle();
      #1;
      model_eval();
   endtask

   // Advance the model alongside one DUT clock edge; returns at the negedge.
   task automatic tick();
      int nmc, n16, n4;
      bit np;
      model_eval();
      nmc = m_mc; n16 = m_cnt16; n4 = m_cnt4; np = hif.debug_step;
      if (rst) begin
         nmc = 0; n16 = 0; n4 = 0; np = 1'b0;
      end else if (!e_susp) begin
         if (e_busy) nmc = m_mc - 1;
         else if (hif.id_mc_start && !e_stall) nmc = ML - 1;
         if (e_busy || e_stall) begin
            if (n16 < 65535) n16++;
            if (n4 < 15) n4++;
         end
      end
      @(posedge clk);
      m_mc = nmc; m_cnt16 = n16; m_cnt4 = n4; m_prev = np;
      @(negedge clk);
   endtask

   task automatic idle();
      hif.debug_en = 1'b0;  hif.debug_step = 1'b0;
      hif.id_rs_addr = '0;  hif.id_rt_addr = '0;
      hif.id_rs_used = 1'b0; hif.id_rt_used = 1'b0;
      hif.id_is_branch = 1'b0; hif.id_mc_start = 1'b0; hif.branch_taken = 1'b0;
      hif.stg_wen = '0; hif.stg_waddr = '0; hif.stg_is_load = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      hif.stg_wen[0] = 1'b1; hif.stg_waddr[0 +: AW] = 5'd3;
      hif.id_rs_addr = 5'd3; hif.id_rs_used = 1'b1; hif.branch_taken = 1'b1;
      tick(); tick();
      settle();
      n_checks++; if (hif.fwd_a !== 2'd0) begin n_fail++; $display("FAIL reset_fwd_a: got %0d want 0", hif.fwd_a); end
      n_checks++; if (hif.data_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b want 0", hif.data_stall); end
      n_checks++; if (act_en() !== 5'b11111) begin n_fail++; $display("FAIL reset_en: got %b want 11111", act_en()); end
      n_checks++; if (act_rs() !== 5'b11111) begin n_fail++; $display("FAIL reset_rs: got %b want 11111", act_rs()); end
      n_checks++; if (hif.mc_busy !== 1'b0 || hif.stall_cnt !== 16'd0 || hif4.stall_cnt !== 4'd0) begin
         n_fail++; $display("FAIL reset_regs: busy %0b cnt %0d cnt4 %0d want 0 0 0", hif.mc_busy, hif.stall_cnt, hif4.stall_cnt);
      end
      rst = 1'b0;
      idle();
      tick();
   endtask

   task automatic test_forward();
      idle();
      hif.stg_wen[0] = 1'b1; hif.stg_waddr[0 +: AW] = 5'd3;
      hif.id_rs_addr = 5'd3; hif.id_rs_used = 1'b1;
      settle();
      n_checks++; if (hif.fwd_a !== 2'd1 || hif.data_stall !== 1'b0) begin
         n_fail++; $display("FAIL fwd_exe: got fwd %0d stall %0b want 1 0", hif.fwd_a, hif.data_stall); end
      hif.stg_wen[1] = 1'b1; hif.stg_waddr[AW +: AW] = 5'd3;
      settle();
      n_checks++; if (hif.fwd_a !== 2'd1) begin n_fail++; $display("FAIL fwd_youngest: got %0d want 1", hif.fwd_a); end
      hif.stg_wen[0] = 1'b0; hif.stg_wen[2] = 1'b1; hif.stg_waddr[2*AW +: AW] = 5'd3;
      settle();
      n_checks++; if (hif.fwd_a !== 2'd2) begin n_fail++; $display("FAIL fwd_mem: got %0d want 2", hif.fwd_a); end
      hif.id_rs_addr = 5'd0; hif.stg_waddr = '0; hif.stg_wen = 3'b111;
      settle();
      n_checks++; if (hif.fwd_a !== 2'd0) begin n_fail++; $display("FAIL fwd_r0: got %0d want 0", hif.fwd_a); end
      for (int i = 0; i < 60; i++) begin
         hif.id_rs_addr = 5'($urandom_range(0, 3)); hif.id_rt_addr = 5'($urandom_range(0, 3));
         hif.id_rs_used = 1'($urandom); hif.id_rt_used = 1'($urandom);
         hif.id_is_branch = 1'($urandom); hif.stg_wen = 3'($urandom); hif.stg_is_load = 3'($urandom);
         for (int k = 0; k < NS; k++) hif.stg_waddr[k*AW +: AW] = 5'($urandom_range(0, 3));
         settle();
         n_checks++; if ({hif.fwd_a, hif.fwd_b, hif.data_stall} !== {e_fwd_a, e_fwd_b, e_stall}) begin
            n_fail++; $display("FAIL fwd_rand: got a%0d b%0d s%0b want a%0d b%0d s%0b",
                               hif.fwd_a, hif.fwd_b, hif.data_stall, e_fwd_a, e_fwd_b, e_stall); end
         n_checks++; if (act_en() !== e_en || hif.stall_cnt !== 16'(m_cnt16)) begin
            n_fail++; $display("FAIL fwd_rand_ctl: got en %b cnt %0d want en %b cnt %0d", act_en(), hif.stall_cnt, e_en, m_cnt16); end
         tick();
      end
   endtask

   task automatic test_load_use();
      int c0;
      idle();
      c0 = m_cnt16;
      hif.stg_wen[0] = 1'b1; hif.stg_waddr[0 +: AW] = 5'd5; hif.stg_is_load[0] = 1'b1;
      hif.id_rt_addr = 5'd5; hif.id_rt_used = 1'b1;
      settle();
      n_checks++; if (hif.data_stall !== 1'b1 || act_en() !== 5'b00111 || act_rs() !== 5'b00100) begin
         n_fail++; $display("FAIL load_use: got stall %0b en %b rs %b want 1 00111 00100", hif.data_stall, act_en(), act_rs()); end
      tick();
      n_checks++; if (hif.stall_cnt !== 16'(c0 + 1)) begin n_fail++; $display("FAIL load_use_cnt: got %0d want %0d", hif.stall_cnt, c0 + 1); end
      hif.stg_wen = 3'b010; hif.stg_waddr[AW +: AW] = 5'd5; hif.stg_is_load = 3'b010;
      settle();
      n_checks++; if (hif.fwd_b !== 2'd2 || hif.data_stall !== 1'b0) begin
         n_fail++; $display("FAIL load_mem_fwd: got fwd %0d stall %0b want 2 0", hif.fwd_b, hif.data_stall); end
      tick();
   endtask

   task automatic test_branch();
      idle();
      hif.id_is_branch = 1'b1; hif.id_rs_addr = 5'd7; hif.id_rs_used = 1'b1;
      hif.stg_wen[0] = 1'b1; hif.stg_waddr[0 +: AW] = 5'd7;
      settle();
      n_checks++; if (hif.data_stall !== 1'b1) begin n_fail++; $display("FAIL br_exe: got %0b want 1", hif.data_stall); end
      hif.stg_wen = 3'b010; hif.stg_waddr[AW +: AW] = 5'd7; hif.stg_is_load = 3'b010;
      settle();
      n_checks++; if (hif.data_stall !== 1'b1) begin n_fail++; $display("FAIL br_mem_load: got %0b want 1", hif.data_stall); end
      hif.stg_is_load = 3'b000;
      settle();
      n_checks++; if (hif.fwd_a !== 2'd2 || hif.data_stall !== 1'b0) begin
         n_fail++; $display("FAIL br_mem_alu: got fwd %0d stall %0b want 2 0", hif.fwd_a, hif.data_stall); end
      hif.branch_taken = 1'b1;
      settle();
      n_checks++; if (act_rs() !== 5'b01000 || act_en() !== 5'b11111) begin
         n_fail++; $display("FAIL br_flush: got rs %b en %b want 01000 11111", act_rs(), act_en()); end
      tick();
      hif.branch_taken = 1'b0;
      settle();
      n_checks++; if (act_rs() !== 5'b00000) begin n_fail++; $display("FAIL br_flush_once: got %b want 00000", act_rs()); end
      hif.branch_taken = 1'b1; hif.stg_wen = 3'b001; hif.stg_waddr[0 +: AW] = 5'd7; hif.stg_is_load = 3'b001;
      settle();
      n_checks++; if (act_rs() !== 5'b00100 || hif.data_stall !== 1'b1) begin
         n_fail++; $display("FAIL br_flush_suppressed: got rs %b stall %0b want 00100 1", act_rs(), hif.data_stall); end
      tick();
      idle();
      tick();
   endtask

   task automatic test_multicycle();
      int c0, busy_n;
      idle();
      c0 = m_cnt16;
      busy_n = 0;
      hif.id_mc_start = 1'b1;
      settle();
      n_checks++; if (hif.mc_busy !== 1'b0) begin n_fail++; $display("FAIL mc_pre: got %0b want 0", hif.mc_busy); end
      tick();
      for (int i = 0; i < 10; i++) begin
         settle();
         if (hif.mc_busy !== 1'b1) break;
         busy_n++;
         n_checks++; if (act_en() !== 5'b00011 || act_rs() !== 5'b00010) begin
            n_fail++; $display("FAIL mc_ctl: got en %b rs %b want 00011 00010", act_en(), act_rs()); end
         tick();
         hif.id_mc_start = 1'b0;
      end
      n_checks++; if (busy_n !== ML - 1) begin n_fail++; $display("FAIL mc_len: got %0d cycles want %0d", busy_n, ML - 1); end
      n_checks++; if (hif.stall_cnt !== 16'(c0 + ML - 1)) begin
         n_fail++; $display("FAIL mc_cnt: got %0d want %0d", hif.stall_cnt, c0 + ML - 1); end
      tick();
   endtask

   task automatic test_debug();
      int busy_n;
      idle();
      busy_n = 0;
      hif.id_mc_start = 1'b1;
      tick();
      hif.id_mc_start = 1'b0;
      hif.debug_en = 1'b1; hif.debug_step = 1'b1;
      settle();
      n_checks++; if (act_en() !== e_en) begin n_fail++; $display("FAIL dbg_first_edge: got %b want %b", act_en(), e_en); end
      tick();
      for (int i = 0; i < 4; i++) begin
         settle();
         n_checks++; if (act_en() !== 5'b00000 || hif.mc_busy !== 1'b1 || hif.stall_cnt !== 16'(m_cnt16)) begin
            n_fail++; $display("FAIL dbg_hold: got en %b busy %0b cnt %0d want 00000 1 %0d", act_en(), hif.mc_busy, hif.stall_cnt, m_cnt16); end
         tick();
      end
      hif.debug_step = 1'b0;
      settle();
      n_checks++; if (act_en() !== 5'b00000) begin n_fail++; $display("FAIL dbg_low: got %b want 00000", act_en()); end
      tick();
      hif.debug_step = 1'b1;
      settle();
      n_checks++; if (act_en() !== 5'b00011) begin n_fail++; $display("FAIL dbg_step: got %b want 00011", act_en()); end
      tick();
      settle();
      n_checks++; if (act_en() !== 5'b00000) begin n_fail++; $display("FAIL dbg_one_step: got %b want 00000", act_en()); end
      hif.debug_en = 1'b0; hif.debug_step = 1'b0;
      for (int i = 0; i < 10; i++) begin
         settle();
         if (hif.mc_busy !== 1'b1) break;
         busy_n++;
         tick();
      end
      n_checks++; if (busy_n !== ML - 3) begin n_fail++; $display("FAIL dbg_frozen: got %0d remaining want %0d", busy_n, ML - 3); end
      tick();
   endtask

   task automatic test_reset_mid();
      idle();
      hif.id_mc_start = 1'b1;
      tick();
      hif.id_mc_start = 1'b0;
      tick();
      rst = 1'b1;
      settle();
      n_checks++; if (act_rs() !== 5'b11111) begin n_fail++; $display("FAIL rmid_rs: got %b want 11111", act_rs()); end
      tick();
      settle();
      n_checks++; if (hif.mc_busy !== 1'b0 || hif.stall_cnt !== 16'd0) begin
         n_fail++; $display("FAIL rmid_clear: got busy %0b cnt %0d want 0 0", hif.mc_busy, hif.stall_cnt); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_saturate();
      rst = 1'b1; idle(); tick(); rst = 1'b0;
      hif.stg_wen[0] = 1'b1; hif.stg_waddr[0 +: AW] = 5'd5; hif.stg_is_load[0] = 1'b1;
      hif.id_rt_addr = 5'd5; hif.id_rt_used = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      settle();
      n_checks++; if (hif4.stall_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_cnt4: got %0d want 15", hif4.stall_cnt); end
      n_checks++; if (hif.stall_cnt !== 16'd20) begin n_fail++; $display("FAIL sat_cnt16: got %0d want 20", hif.stall_cnt); end
      idle();
      tick();
   endtask

   task automatic test_random_all();
      for (int i = 0; i < 300; i++) begin
         rst = ($urandom_range(0, 29) == 0);
         hif.debug_en = ($urandom_range(0, 3) == 0); hif.debug_step = 1'($urandom);
         hif.id_rs_addr = 5'($urandom_range(0, 3)); hif.id_rt_addr = 5'($urandom_range(0, 3));
         hif.id_rs_used = 1'($urandom); hif.id_rt_used = 1'($urandom);
         hif.id_is_branch = 1'($urandom); hif.id_mc_start = ($urandom_range(0, 5) == 0);
         hif.branch_taken = ($urandom_range(0, 3) == 0);
         hif.stg_wen = 3'($urandom); hif.stg_is_load = 3'($urandom);
         for (int k = 0; k < NS; k++) hif.stg_waddr[k*AW +: AW] = 5'($urandom_range(0, 3));
         settle();
         n_checks++; if ({hif.fwd_a, hif.fwd_b, hif.data_stall, hif.mc_busy} !== {e_fwd_a, e_fwd_b, e_stall, e_busy}) begin
            n_fail++; $display("FAIL rand_dp: got a%0d b%0d s%0b m%0b want a%0d b%0d s%0b m%0b", hif.fwd_a, hif.fwd_b,
                               hif.data_stall, hif.mc_busy, e_fwd_a, e_fwd_b, e_stall, e_busy); end
         n_checks++; if (act_en() !== e_en || act_rs() !== e_rs) begin
            n_fail++; $display("FAIL rand_ctl: got en %b rs %b want en %b rs %b", act_en(), act_rs(), e_en, e_rs); end
         n_checks++; if (hif.stall_cnt !== 16'(m_cnt16) || hif4.stall_cnt !== 4'(m_cnt4)) begin
            n_fail++; $display("FAIL rand_cnt: got %0d/%0d want %0d/%0d", hif.stall_cnt, hif4.stall_cnt, m_cnt16, m_cnt4); end
         tick();
      end
      rst = 1'b0;
      idle();
   endtask

   initial begin
      rst = 1'b1;
      idle();
      @(negedge clk);
      test_reset();
      test_forward();
      test_load_use();
      test_branch();
      test_multicycle();
      test_debug();
      test_reset_mid();
      test_saturate();
      test_random_all();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
